// File: rtl/mpc_acc_rnd_sat_30_21.sv
// Dot-product accumulator: sums signed product terms per block, then rounds
// (half toward +inf), drops SHIFT fractional bits and saturates to OUT_W.
// Pipeline: stage 1 accumulate, stage 2 round/shift, stage 3 clip.
//
// Handshake: a term is accepted on a rising clk edge when ce && in_valid.
// There is no backpressure. in_last is only looked at on an accepted term.
// y_valid is high for exactly one enabled cycle per closed block, two
// enabled edges after the closing term. y and sat hold between results.
module mpc_acc_rnd_sat_30_21 #(
   parameter int IN_W      = 30,
   parameter int ACC_W     = 37,
   parameter int SHIFT     = 8,
   parameter int OUT_W     = 21,
   parameter int MAX_TERMS = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic signed [IN_W-1:0]  p,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic signed [OUT_W-1:0] y,
   output logic                    y_valid,
   output logic                    sat,
   output logic                    term_err
);

   localparam int CNT_W = $clog2(MAX_TERMS + 1);
   localparam int S2_W  = ACC_W + 1 - SHIFT;

   localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(MAX_TERMS);
   localparam logic signed [ACC_W:0]   RND_BIAS = (ACC_W+1)'(1) << (SHIFT - 1);
   localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [S2_W-1:0]  S2_MAX   = {{(S2_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [S2_W-1:0]  S2_MIN   = {{(S2_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Stage 1 state: running sum and term count (count 0 means block empty).
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] s1_sum;
   logic                    s1_valid;
   // Stage 2 state: rounded and shifted sum.
   logic signed [S2_W-1:0]  s2;
   logic                    s2_valid;

   logic                    term_take;
   logic signed [ACC_W-1:0] p_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W:0]   rnd_sum;
   logic signed [S2_W-1:0]  s2_next;
   logic                    clip_hi;
   logic                    clip_lo;
   logic signed [OUT_W-1:0] y_next;

   assign term_take = ce && in_valid;
   assign p_ext     = {{(ACC_W-IN_W){p[IN_W-1]}}, p};

   // New accumulated value: an empty block restarts from the incoming term.
   always_comb begin
      acc_sum = p_ext;
      if (cnt != '0) begin
         acc_sum = acc + p_ext;
      end
   end

   // Round half toward +inf: add half an LSB of the result, then shift arithmetically.
   always_comb begin
      rnd_sum = {s1_sum[ACC_W-1], s1_sum} + RND_BIAS;
      s2_next = S2_W'(rnd_sum >>> SHIFT);
   end

   // Clip the rounded value into the signed OUT_W range.
   always_comb begin
      clip_hi = (s2 > S2_MAX);
      clip_lo = (s2 < S2_MIN);
      y_next  = s2[OUT_W-1:0];
      if (clip_hi) begin
         y_next = OUT_MAX;
      end else if (clip_lo) begin
         y_next = OUT_MIN;
      end
   end

   // Accumulator, term counter and sticky overrun flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         term_err <= 1'b0;
      end else if (term_take) begin
         if (in_last) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_sum;
            if (cnt == CNT_MAX) begin
               term_err <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // Capture the completed block sum when the closing term is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_sum   <= '0;
         s1_valid <= 1'b0;
      end else if (ce) begin
         s1_valid <= term_take && in_last;
         if (term_take && in_last) begin
            s1_sum <= acc_sum;
         end
      end
   end

   // Register the rounded, shifted sum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2       <= '0;
         s2_valid <= 1'b0;
      end else if (ce) begin
         s2       <= s2_next;
         s2_valid <= s1_valid;
      end
   end

   // Output register: y and sat change only when a new result arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y       <= '0;
         sat     <= 1'b0;
         y_valid <= 1'b0;
      end else if (ce) begin
         y_valid <= s2_valid;
         if (s2_valid) begin
            y   <= y_next;
            sat <= clip_hi || clip_lo;
         end
      end
   end

endmodule

// File: tb/tb_mpc_acc_rnd_sat_30_21.sv
// Bench for mpc_acc_rnd_sat_30_21: table of blocks applied back to back,
// random blocks against a rounding/saturation model, and hand sequences for
// latency, ce freeze, reset abort and term overrun.
module tb_mpc_acc_rnd_sat_30_21;

   localparam int IN_W      = 30;
   localparam int ACC_W     = 37;
   localparam int SHIFT     = 8;
   localparam int OUT_W     = 21;
   localparam int MAX_TERMS = 64;
   localparam int N_VEC     = 14;

   localparam longint YMAX = (longint'(1) << (OUT_W - 1)) - 1;
   localparam longint YMIN = -(longint'(1) << (OUT_W - 1));

   typedef struct {
      int   n;
      int   t[4];
      int   y;
      logic sat;
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic                    clk = 1'b0;
   logic                    rst;
   logic                    ce;
   logic signed [IN_W-1:0]  p;
   logic                    in_valid;
   logic                    in_last;
   logic signed [OUT_W-1:0] y;
   logic                    y_valid;
   logic                    sat;
   logic                    term_err;

   always #5 clk = ~clk;

   mpc_acc_rnd_sat_30_21 #(
      .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .MAX_TERMS(MAX_TERMS)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .p(p), .in_valid(in_valid), .in_last(in_last),
      .y(y), .y_valid(y_valid), .sat(sat), .term_err(term_err)
   );

   // ---------------- scoreboard state ----------------
   int             n_checks = 0;
   int             n_fail   = 0;
   logic [OUT_W:0] exp_q[$];
   logic [OUT_W:0] mon_e;
   logic           ce_at_edge = 1'b0;
   vec_t           vecs[N_VEC];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic c, input logic v, input logic l, input int pv);
      ce       = c;
      in_valid = v;
      in_last  = l;
      p        = IN_W'(pv);
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input longint sum);
      longint                  r;
      logic                    s;
      logic signed [OUT_W-1:0] yv;
      r = (sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
      if (r > YMAX) begin
         yv = OUT_W'(YMAX);
         s  = 1'b1;
      end else if (r < YMIN) begin
         yv = OUT_W'(YMIN);
         s  = 1'b1;
      end else begin
         yv = OUT_W'(r);
         s  = 1'b0;
      end
      exp_q.push_back({s, yv});
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         step(1'b1, 1'b0, 1'b0, 0);
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic pulse_rst();
      rst = 1'b0;
      #2;
      check("rst_y_valid", int'(y_valid), 0);
      rst = 1'b1;
   endtask

   task automatic set_vec(input int i, input int n, input int t0, input int t1,
                          input int t2, input int t3, input int yv, input logic s);
      vecs[i].n    = n;
      vecs[i].t[0] = t0;
      vecs[i].t[1] = t1;
      vecs[i].t[2] = t2;
      vecs[i].t[3] = t3;
      vecs[i].y    = yv;
      vecs[i].sat  = s;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) ce_at_edge <= ce;

   always @(negedge clk) begin
      if (rst && y_valid && ce_at_edge) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("y", int'(y), int'($signed(mon_e[OUT_W-1:0])));
            check("sat", int'(sat), int'(mon_e[OUT_W]));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; ce = 1'b0; in_valid = 1'b0; in_last = 1'b0; p = '0;

      set_vec(0,  2, 128000, 128000, 0, 0, 1000, 1'b0);
      set_vec(1,  1, 384, 0, 0, 0, 2, 1'b0);
      set_vec(2,  1, -384, 0, 0, 0, -1, 1'b0);
      set_vec(3,  2, 536870911, 536870911, 0, 0, 1048575, 1'b1);
      set_vec(4,  2, -536870912, -536870912, 0, 0, -1048576, 1'b1);
      set_vec(5,  1, 127, 0, 0, 0, 0, 1'b0);
      set_vec(6,  1, 128, 0, 0, 0, 1, 1'b0);
      set_vec(7,  1, -128, 0, 0, 0, 0, 1'b0);
      set_vec(8,  1, -129, 0, 0, 0, -1, 1'b0);
      set_vec(9,  3, 1000, -3000, 500, 0, -6, 1'b0);
      set_vec(10, 1, 268435072, 0, 0, 0, 1048575, 1'b0);
      set_vec(11, 1, 268435328, 0, 0, 0, 1048575, 1'b1);
      set_vec(12, 1, -268435584, 0, 0, 0, -1048576, 1'b0);
      set_vec(13, 1, -268435585, 0, 0, 0, -1048576, 1'b1);

      // Reset state while rst is held low.
      #12;
      check("reset_y", int'(y), 0);
      check("reset_y_valid", int'(y_valid), 0);
      check("reset_sat", int'(sat), 0);
      check("reset_term_err", int'(term_err), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Latency: result two enabled edges after the closing term, one cycle wide.
      step(1'b1, 1'b1, 1'b0, 128000);
      push_exp(256000);
      step(1'b1, 1'b1, 1'b1, 128000);
      check("lat_k0", int'(y_valid), 0);
      step(1'b1, 1'b0, 1'b0, 0);
      check("lat_k1", int'(y_valid), 0);
      step(1'b1, 1'b0, 1'b0, 0);
      check("lat_k2", int'(y_valid), 1);
      step(1'b1, 1'b0, 1'b0, 0);
      check("lat_k3", int'(y_valid), 0);
      check("hold_y", int'(y), 1000);

      // Back-to-back single-term blocks give consecutive results.
      push_exp(384);
      step(1'b1, 1'b1, 1'b1, 384);
      push_exp(-384);
      step(1'b1, 1'b1, 1'b1, -384);
      step(1'b1, 1'b0, 1'b0, 0);
      check("btb_first", int'(y_valid), 1);
      step(1'b1, 1'b0, 1'b0, 0);
      check("btb_second", int'(y_valid), 1);
      step(1'b1, 1'b0, 1'b0, 0);
      check("btb_after", int'(y_valid), 0);

      // Table, applied back to back.
      for (int i = 0; i < N_VEC; i++) begin
         for (int j = 0; j < vecs[i].n; j++) begin
            if (j == vecs[i].n - 1) begin
               exp_q.push_back({vecs[i].sat, OUT_W'(vecs[i].y)});
            end
            step(1'b1, 1'b1, (j == vecs[i].n - 1), vecs[i].t[j]);
         end
      end
      wait_drain();

      // Random blocks with in_valid gaps (some gaps carry a stray in_last).
      for (int b = 0; b < 20; b++) begin
         int     n;
         int     pv;
         longint sum;
         n   = int'($urandom_range(4, 1));
         sum = 0;
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(3, 0) == 0) begin
               step(1'b1, 1'b0, 1'($urandom_range(1, 0)), int'($urandom));
            end
            pv  = int'($urandom_range(1073741823, 0)) - 536870912;
            sum = sum + longint'(pv);
            if (j == n - 1) begin
               push_exp(sum);
            end
            step(1'b1, 1'b1, (j == n - 1), pv);
         end
      end
      wait_drain();

      // Reset aborts an in-flight result and a partial block.
      step(1'b1, 1'b1, 1'b0, 1000);
      step(1'b1, 1'b1, 1'b0, 1000);
      step(1'b1, 1'b1, 1'b1, 1000);
      pulse_rst();
      step(1'b1, 1'b1, 1'b0, 1000);
      step(1'b1, 1'b1, 1'b0, 1000);
      step(1'b1, 1'b1, 1'b0, 1000);
      pulse_rst();
      push_exp(512);
      step(1'b1, 1'b1, 1'b1, 512);
      wait_drain();
      check("abort_y", int'(y), 2);

      // ce low freezes everything; in_valid gaps just delay the block.
      step(1'b1, 1'b1, 1'b0, 256);
      step(1'b0, 1'b1, 1'b1, 999);
      step(1'b0, 1'b1, 1'b1, 999);
      step(1'b1, 1'b0, 1'b1, 777);
      push_exp(512);
      step(1'b1, 1'b1, 1'b1, 256);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      check("ce_delay_y_valid", int'(y_valid), 0);
      step(1'b1, 1'b0, 1'b0, 0);
      check("ce_result_y_valid", int'(y_valid), 1);
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      check("ce_freeze_y_valid", int'(y_valid), 1);
      step(1'b1, 1'b0, 1'b0, 0);
      check("ce_release_y_valid", int'(y_valid), 0);
      check("ce_y", int'(y), 2);

      // Term overrun: the 65th non-closing term sets the sticky flag.
      for (int i = 0; i < 65; i++) begin
         step(1'b1, 1'b1, 1'b0, 1);
         if (i == 63) begin
            check("term_err_at_64", int'(term_err), 0);
         end
      end
      check("term_err_at_65", int'(term_err), 1);
      push_exp(65);
      step(1'b1, 1'b1, 1'b1, 0);
      wait_drain();
      check("term_err_y", int'(y), 0);
      check("term_err_sticky", int'(term_err), 1);
      push_exp(384);
      step(1'b1, 1'b1, 1'b1, 384);
      wait_drain();
      check("term_err_still", int'(term_err), 1);
      pulse_rst();
      check("term_err_cleared", int'(term_err), 0);
      check("rst_y_cleared", int'(y), 0);
      step(1'b1, 1'b0, 1'b0, 0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
